// File: rtl/inst_rom_loader.sv
// Instruction memory for the core's fetch port, filled by a byte-serial big-endian loader.
// run_o stays low until a complete image has been loaded, holding the core in reset.
module inst_rom_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  output logic [31:0] inst_o,
  input  logic        ld_start_i,
  input  logic [7:0]  ld_byte_i,
  input  logic        ld_valid_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  output logic        ld_done_o,
  output logic        ld_err_o,
  output logic        run_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e          state_q;
  logic [ADDR_W:0] wp_q;
  logic [1:0]      bc_q;
  logic [31:0]     asm_q;
  logic            done_q;
  logic            err_q;
  logic [31:0]     mem [Depth];

  logic        accept;
  logic        word_wr;
  logic        wp_full;
  logic        fetch_hit;
  logic [31:0] word;

  assign accept  = (state_q == StLoad) & ld_valid_i;
  assign word_wr = accept & ((bc_q == 2'd3) | ld_last_i);
  // wp saturates at Depth, so its MSB is set only once every word slot is used
  assign wp_full = wp_q[ADDR_W];

  // Merge the incoming byte into the assembly word; unfilled low bytes stay zero.
  always_comb begin
    word = asm_q;
    unique case (bc_q)
      2'd0: word[31:24] = ld_byte_i;
      2'd1: word[23:16] = ld_byte_i;
      2'd2: word[15:8]  = ld_byte_i;
      2'd3: word[7:0]   = ld_byte_i;
      default: word = asm_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wp_q    <= '0;
      bc_q    <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StRun: begin
          if (ld_start_i) begin
            state_q <= StLoad;
            wp_q    <= '0;
            bc_q    <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        StLoad: begin
          if (ld_valid_i) begin
            if (word_wr) begin
              asm_q <= '0;
              bc_q  <= '0;
              if (wp_full) begin
                err_q <= 1'b1;
              end else begin
                wp_q <= wp_q + {{ADDR_W{1'b0}}, 1'b1};
              end
            end else begin
              asm_q <= word;
              bc_q  <= bc_q + 2'd1;
            end
            if (ld_last_i) begin
              state_q <= StRun;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Contents are deliberately not reset; only whole (or last, padded) words are written.
  always_ff @(posedge clk) begin
    if (word_wr && !wp_full) begin
      mem[wp_q[ADDR_W-1:0]] <= word;
    end
  end

  // Combinational read: the core latches rom_data_i in the cycle the address is presented.
  assign fetch_hit = ce_i & run_o & ((addr_i >> (ADDR_W + 2)) == 32'd0);
  assign inst_o    = fetch_hit ? mem[addr_i[ADDR_W+1:2]] : 32'h0;

  assign ld_ready_o = (state_q == StLoad);
  assign run_o      = (state_q == StRun);
  assign ld_done_o  = done_q;
  assign ld_err_o   = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: two instances (ADDR_W=10 and ADDR_W=2) share one stimulus
// stream and are checked every cycle against a byte-queue model plus literal expectations.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        ld_start;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_last;

  logic [31:0] inst_b, inst_s;
  logic        rdy_b, rdy_s, done_b, done_s, err_b, err_s, run_b, run_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(10)) u_big (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce),
    .addr_i     (addr),
    .inst_o     (inst_b),
    .ld_start_i (ld_start),
    .ld_byte_i  (ld_byte),
    .ld_valid_i (ld_valid),
    .ld_last_i  (ld_last),
    .ld_ready_o (rdy_b),
    .ld_done_o  (done_b),
    .ld_err_o   (err_b),
    .run_o      (run_b)
  );

  inst_rom_loader #(.ADDR_W(2)) u_small (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce),
    .addr_i     (addr),
    .inst_o     (inst_s),
    .ld_start_i (ld_start),
    .ld_byte_i  (ld_byte),
    .ld_valid_i (ld_valid),
    .ld_last_i  (ld_last),
    .ld_ready_o (rdy_s),
    .ld_done_o  (done_s),
    .ld_err_o   (err_s),
    .run_o      (run_s)
  );

  // Model: the image is the queue of accepted bytes; word k is bytes 4k..4k+3, zero padded.
  logic [7:0]  m_q [$];
  bit          m_loading = 1'b0;
  bit          m_running = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err0 = 1'b0;
  bit          m_err1 = 1'b0;
  logic [31:0] m_mem0 [1024];
  bit          m_known0 [1024];
  logic [31:0] m_mem1 [4];
  bit          m_known1 [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_running = 1'b0;
    m_done    = 1'b0;
    m_err0    = 1'b0;
    m_err1    = 1'b0;
    m_q.delete();
  endtask

  task automatic model_write(input int idx);
    logic [31:0] w;
    int j;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      j = 4 * idx + k;
      w = {w[23:0], (j < m_q.size()) ? m_q[j] : 8'h00};
    end
    if (idx < 1024) begin
      m_mem0[idx] = w;
      m_known0[idx] = 1'b1;
    end else begin
      m_err0 = 1'b1;
    end
    if (idx < 4) begin
      m_mem1[idx] = w;
      m_known1[idx] = 1'b1;
    end else begin
      m_err1 = 1'b1;
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples on that edge.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (!m_loading) begin
      if (ld_start) begin
        m_loading = 1'b1;
        m_running = 1'b0;
        m_err0    = 1'b0;
        m_err1    = 1'b0;
        m_q.delete();
      end
    end else if (ld_valid) begin
      m_q.push_back(ld_byte);
      if ((m_q.size() % 4) == 0 || ld_last) model_write((m_q.size() - 1) / 4);
      if (ld_last) begin
        m_loading = 1'b0;
        m_running = 1'b1;
        m_done    = 1'b1;
      end
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("ready_big", {31'b0, rdy_b}, {31'b0, m_loading});
      chk("ready_small", {31'b0, rdy_s}, {31'b0, m_loading});
      chk("run_big", {31'b0, run_b}, {31'b0, m_running});
      chk("run_small", {31'b0, run_s}, {31'b0, m_running});
      chk("done_big", {31'b0, done_b}, {31'b0, m_done});
      chk("done_small", {31'b0, done_s}, {31'b0, m_done});
      chk("err_big", {31'b0, err_b}, {31'b0, m_err0});
      chk("err_small", {31'b0, err_s}, {31'b0, m_err1});
      if (ce && m_running && addr[31:12] == 20'h0) begin
        if (m_known0[addr[11:2]]) chk("inst_big", inst_b, m_mem0[addr[11:2]]);
      end else begin
        chk("inst_big", inst_b, 32'h0);
      end
      if (ce && m_running && addr[31:4] == 28'h0) begin
        if (m_known1[addr[3:2]]) chk("inst_small", inst_s, m_mem1[addr[3:2]]);
      end else begin
        chk("inst_small", inst_s, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic fetch_chk(input logic [31:0] a, input logic [31:0] eb, input logic [31:0] es);
    addr = a;
    #1;
    chk("fetch_big", inst_b, eb);
    chk("fetch_small", inst_s, es);
    tick();
  endtask

  task automatic reset_mid_cycle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_run", {30'b0, run_b, run_s}, 32'h0);
    chk("rst_ready", {30'b0, rdy_b, rdy_s}, 32'h0);
    chk("rst_done_err", {28'b0, done_b, done_s, err_b, err_s}, 32'h0);
    chk("rst_inst", inst_b | inst_s, 32'h0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [7:0] img1 [8];

  initial begin
    img1 = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h00, 8'h05};
    rst = 1'b1;
    ce = 1'b1;
    addr = 32'h0;
    ld_start = 1'b0;
    ld_byte = 8'h00;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    repeat (2) tick();
    #1;
    chk("init_run_inst", {31'b0, run_b} | inst_b, 32'h0);
    rst = 1'b0;
    tick();

    // Two-word image
    start_load();
    #1;
    chk("load_ready", {30'b0, rdy_b, rdy_s}, 32'h3);
    for (int i = 0; i < 8; i++) begin
      send_byte(img1[i], i == 7);
      #1;
      if (i == 6) chk("done_early", {31'b0, done_b}, 32'h0);
    end
    chk("done_pulse", {28'b0, done_b, done_s, run_b, run_s}, 32'hF);
    tick();
    #1;
    chk("done_drop", {28'b0, done_b, done_s, run_b, run_s}, 32'h3);
    fetch_chk(32'h0, 32'h3C011234, 32'h3C011234);
    fetch_chk(32'h4, 32'h34210005, 32'h34210005);
    fetch_chk(32'h6, 32'h34210005, 32'h34210005);

    // Reset while running
    addr = 32'h0;
    reset_mid_cycle();

    // Partial word
    start_load();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    fetch_chk(32'h0, 32'hAABBCC00, 32'hAABBCC00);
    fetch_chk(32'h0000_1000, 32'h0, 32'h0);
    fetch_chk(32'h4, 32'h34210005, 32'h34210005);
    ce = 1'b0;
    fetch_chk(32'h0, 32'h0, 32'h0);
    ce = 1'b1;

    // Reload from RUN
    addr = 32'h0;
    start_load();
    #1;
    chk("reload_run", {30'b0, run_b, run_s}, 32'h0);
    chk("reload_ready", {30'b0, rdy_b, rdy_s}, 32'h3);
    chk("reload_inst", inst_b, 32'h0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    fetch_chk(32'h0, 32'h11223344, 32'h11223344);
    fetch_chk(32'h4, 32'h34210005, 32'h34210005);

    // Overflow on the 4-word instance; start held on the first byte must be ignored
    start_load();
    for (int i = 0; i < 20; i++) begin
      ld_start = (i == 0);
      send_byte(8'(8'h40 + i), i == 19);
      ld_start = 1'b0;
      if (i == 15) begin
        #1;
        chk("err_before_ovf", {31'b0, err_s}, 32'h0);
      end
    end
    #1;
    chk("err_after_ovf", {30'b0, err_b, err_s}, 32'h1);
    chk("run_after_ovf", {30'b0, run_b, run_s}, 32'h3);
    fetch_chk(32'h10, 32'h50515253, 32'h0);
    fetch_chk(32'hC, 32'h4C4D4E4F, 32'h4C4D4E4F);
    fetch_chk(32'h0, 32'h40414243, 32'h40414243);
    start_load();
    #1;
    chk("err_cleared", {30'b0, err_b, err_s}, 32'h0);

    // Reset after 6 bytes: word 1 must keep its previous contents
    for (int i = 0; i < 6; i++) send_byte(8'(8'h90 + i), 1'b0);
    reset_mid_cycle();
    ld_valid = 1'b1;
    ld_byte = 8'h77;
    #1;
    chk("idle_not_ready", {30'b0, rdy_b, rdy_s}, 32'h0);
    tick();
    ld_valid = 1'b0;
    start_load();
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    fetch_chk(32'h4, 32'h44454647, 32'h44454647);
    fetch_chk(32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
